// File: rtl/sram_like_arbiter_if.sv
// sram_like_arbiter_if: one sram_like channel (request plus response).
//   req/wr/size/addr/wdata : request, driven by the master side
//   rdata/addr_ok/data_ok  : response, driven by the slave side
// modport master : the side issuing requests (a CPU port, or the arbiter toward the bus)
// modport slave  : the side answering requests (the arbiter toward a CPU port, or memory)
interface sram_like_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        addr_ok;
  logic        data_ok;

  modport master (
    output req, wr, size, addr, wdata,
    input  rdata, addr_ok, data_ok
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output rdata, addr_ok, data_ok
  );
endinterface

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: shares one sram_like slave between an instruction master
// and a data master, with one transaction outstanding at a time.
//   clk  : system clock, rising edge
//   rst  : asynchronous, active-low reset
//   inst : instruction-side channel (arbiter acts as slave)
//   data : data-side channel (arbiter acts as slave)
//   bus  : shared downstream channel (arbiter acts as master)
// Optional feature: define ARB_ROUND_ROBIN_EN for round-robin arbitration
// on simultaneous requests. Without it, data wins over inst.
module sram_like_arbiter (
  input  logic                       clk,
  input  logic                       rst,
  sram_like_arbiter_if.slave         inst,
  sram_like_arbiter_if.slave         data,
  sram_like_arbiter_if.master        bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t state_reg;
  logic   owner_reg;   // 0 = inst, 1 = data
  logic   winner;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_reg;      // master granted most recently

  // On a tie, the master that was not served last gets the bus.
  always_comb begin
    if (inst.req && data.req) winner = ~last_reg;
    else                      winner = data.req;
  end
`else
  assign winner = data.req;
`endif

  // Owner's live request fields; the request is forwarded, not captured,
  // so a master can cancel or change it until the slave accepts.
  logic        owner_req;
  logic        owner_wr;
  logic [1:0]  owner_size;
  logic [31:0] owner_addr;
  logic [31:0] owner_wdata;

  assign owner_req   = owner_reg ? data.req   : inst.req;
  assign owner_wr    = owner_reg ? data.wr    : inst.wr;
  assign owner_size  = owner_reg ? data.size  : inst.size;
  assign owner_addr  = owner_reg ? data.addr  : inst.addr;
  assign owner_wdata = owner_reg ? data.wdata : inst.wdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      owner_reg <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_reg  <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (inst.req || data.req) begin
            owner_reg <= winner;
`ifdef ARB_ROUND_ROBIN_EN
            last_reg  <= winner;
`endif
            state_reg <= REQ;
          end
        end
        REQ: begin
          if (owner_req && bus.addr_ok) state_reg <= WAIT;
          else if (!owner_req)          state_reg <= IDLE;  // cancelled before acceptance
        end
        WAIT: begin
          if (bus.data_ok) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  logic in_req;
  logic in_wait;

  assign in_req  = (state_reg == REQ);
  assign in_wait = (state_reg == WAIT);

  // Request fields are only meaningful in REQ; zero elsewhere.
  assign bus.req   = in_req & owner_req;
  assign bus.wr    = in_req & owner_wr;
  assign bus.size  = in_req ? owner_size  : 2'b00;
  assign bus.addr  = in_req ? owner_addr  : 32'd0;
  assign bus.wdata = in_req ? owner_wdata : 32'd0;

  // Handshakes go only to the owner and only in the phase that expects them;
  // stray slave handshakes in other states are dropped.
  assign inst.addr_ok = in_req  & ~owner_reg & bus.addr_ok;
  assign data.addr_ok = in_req  &  owner_reg & bus.addr_ok;
  assign inst.data_ok = in_wait & ~owner_reg & bus.data_ok;
  assign data.data_ok = in_wait &  owner_reg & bus.data_ok;

  // Read data is broadcast; data_ok alone marks it valid.
  assign inst.rdata = bus.rdata;
  assign data.rdata = bus.rdata;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Testbench for sram_like_arbiter. Inputs change 1 ns after the rising edge,
// outputs are sampled on the falling edge. Completed reads are predicted in a
// queue when the slave accepts an address and are matched when a data_ok
// appears at either master port.
module tb_sram_like_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  sram_like_arbiter_if inst_if ();
  sram_like_arbiter_if data_if ();
  sram_like_arbiter_if bus_if ();

  sram_like_arbiter dut (
    .clk  (clk),
    .rst  (rst),
    .inst (inst_if),
    .data (data_if),
    .bus  (bus_if)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        side;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_req(input logic side, input logic req, input logic wr,
                         input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata);
    if (side) begin
      data_if.req = req; data_if.wr = wr; data_if.size = size;
      data_if.addr = addr; data_if.wdata = wdata;
    end else begin
      inst_if.req = req; inst_if.wr = wr; inst_if.size = size;
      inst_if.addr = addr; inst_if.wdata = wdata;
    end
  endtask

  // Scoreboard monitor: every forwarded data_ok must match a predicted entry.
  always @(negedge clk) begin
    if (inst_if.data_ok || data_if.data_ok) begin
      if (sb_q.size() == 0) begin
        check("unexpected_data_ok", {30'd0, data_if.data_ok, inst_if.data_ok}, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("sb_who", {30'd0, data_if.data_ok, inst_if.data_ok}, mon_e.side ? 32'd2 : 32'd1);
        check("sb_rdata", mon_e.side ? data_if.rdata : inst_if.rdata, mon_e.rdata);
      end
    end
  end

  // Serve one transaction; called in the drive phase of the first REQ cycle.
  task automatic serve(input logic side, input logic wr, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rdata, input string tag);
    logic [31:0] own_ok;
    own_ok = side ? 32'd2 : 32'd1;
    // Stray data_ok during REQ must be ignored.
    bus_if.data_ok = 1'b1;
    bus_if.rdata   = 32'hBAD0_0000;
    sample();
    check({tag, "_bus_req"},   bus_if.req,   32'd1);
    check({tag, "_bus_wr"},    bus_if.wr,    wr);
    check({tag, "_bus_size"},  bus_if.size,  size);
    check({tag, "_bus_addr"},  bus_if.addr,  addr);
    check({tag, "_bus_wdata"}, bus_if.wdata, wdata);
    check({tag, "_aok_idle"},  {data_if.addr_ok, inst_if.addr_ok}, 32'd0);
    drive_cycle();
    bus_if.data_ok = 1'b0;
    bus_if.addr_ok = 1'b1;
    sb_q.push_back('{side, rdata});
    sample();
    check({tag, "_aok"}, {data_if.addr_ok, inst_if.addr_ok}, own_ok);
    drive_cycle();
    // WAIT: addr_ok left high must not be forwarded.
    set_req(side, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
    sample();
    check({tag, "_wait_bus_req"}, bus_if.req, 32'd0);
    check({tag, "_wait_aok"}, {data_if.addr_ok, inst_if.addr_ok}, 32'd0);
    check({tag, "_wait_dok"}, {data_if.data_ok, inst_if.data_ok}, 32'd0);
    drive_cycle();
    bus_if.addr_ok = 1'b0;
    bus_if.data_ok = 1'b1;
    bus_if.rdata   = rdata;
    sample();
    check({tag, "_dok"}, {data_if.data_ok, inst_if.data_ok}, own_ok);
    drive_cycle();
    bus_if.data_ok = 1'b0;
    $display("txn %s: side=%s wr=%0d size=%0d addr=%h wdata=%h rdata=%h",
             tag, side ? "data" : "inst", wr, size, addr, wdata, rdata);
  endtask

  logic first;
  logic s;

  initial begin
    set_req(1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
    set_req(1'b1, 1'b1, 1'b1, 2'd2, 32'hFFFF_0000, 32'h1111_2222);
    bus_if.rdata   = 32'd0;
    bus_if.addr_ok = 1'b1;
    bus_if.data_ok = 1'b1;

    // Reset: outputs quiet despite a pending request and slave handshakes.
    sample();
    check("rst_bus_req",  bus_if.req,  32'd0);
    check("rst_bus_wr",   bus_if.wr,   32'd0);
    check("rst_bus_addr", bus_if.addr, 32'd0);
    check("rst_aok", {data_if.addr_ok, inst_if.addr_ok}, 32'd0);
    check("rst_dok", {data_if.data_ok, inst_if.data_ok}, 32'd0);
    drive_cycle();
    rst = 1'b1;
    bus_if.addr_ok = 1'b0;
    bus_if.data_ok = 1'b0;
    set_req(1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);

    // Single data read.
    drive_cycle();
    set_req(1'b1, 1'b1, 1'b0, 2'd2, 32'h8000_0010, 32'd0);
    sample();
    check("t1_idle_bus_req", bus_if.req, 32'd0);
    drive_cycle();
    serve(1'b1, 1'b0, 2'd2, 32'h8000_0010, 32'd0, 32'h1234_5678, "t1");

    // Simultaneous requests held until served.
`ifdef ARB_ROUND_ROBIN_EN
    first = 1'b0;   // data was granted last
`else
    first = 1'b1;
`endif
    drive_cycle();
    set_req(1'b0, 1'b1, 1'b0, 2'd2, 32'h0000_0100, 32'd0);
    set_req(1'b1, 1'b1, 1'b1, 2'd2, 32'h0000_0200, 32'h0000_0055);
    sample();
    check("t2_idle_bus_req", bus_if.req, 32'd0);
    drive_cycle();
    for (int k = 0; k < 2; k++) begin
      s = (k == 0) ? first : ~first;
      serve(s, s, 2'd2, s ? 32'h0000_0200 : 32'h0000_0100,
            s ? 32'h0000_0055 : 32'd0, s ? 32'h0000_D0D0 : 32'h0000_1A1A, "t2");
      if (k == 0) begin
        sample();
        check("t2_turnaround_bus_req", bus_if.req, 32'd0);
        drive_cycle();
      end
    end

    // Cancel before address acceptance.
    drive_cycle();
    set_req(1'b0, 1'b1, 1'b0, 2'd2, 32'h0000_0300, 32'd0);
    sample();
    check("t3_idle_bus_req", bus_if.req, 32'd0);
    drive_cycle();
    sample();
    check("t3_req_bus_req",  bus_if.req,  32'd1);
    check("t3_req_bus_addr", bus_if.addr, 32'h0000_0300);
    drive_cycle();
    inst_if.req = 1'b0;
    sample();
    check("t3_cancel_bus_req", bus_if.req, 32'd0);
    check("t3_cancel_aok", {data_if.addr_ok, inst_if.addr_ok}, 32'd0);
    drive_cycle();
    bus_if.addr_ok = 1'b1;   // stray, arbiter should be idle
    sample();
    check("t3_idle_aok", {data_if.addr_ok, inst_if.addr_ok}, 32'd0);
    check("t3_idle_bus_req2", bus_if.req, 32'd0);
    $display("txn t3: inst request cancelled in REQ");

    // Byte write, also proves the cancel returned to IDLE.
    drive_cycle();
    bus_if.addr_ok = 1'b0;
    set_req(1'b1, 1'b1, 1'b1, 2'd0, 32'h0000_0003, 32'h0000_00AA);
    sample();
    check("t4_idle_bus_req", bus_if.req, 32'd0);
    drive_cycle();
    serve(1'b1, 1'b1, 2'd0, 32'h0000_0003, 32'h0000_00AA, 32'd0, "t4");

    // Spurious data_ok in IDLE; rdata still broadcast.
    drive_cycle();
    bus_if.data_ok = 1'b1;
    bus_if.rdata   = 32'hDEAD_BEEF;
    sample();
    check("t5_dok", {data_if.data_ok, inst_if.data_ok}, 32'd0);
    check("t5_inst_rdata", inst_if.rdata, 32'hDEAD_BEEF);
    check("t5_data_rdata", data_if.rdata, 32'hDEAD_BEEF);
    $display("txn t5: spurious bus_data_ok in IDLE");
    drive_cycle();
    bus_if.data_ok = 1'b0;
    set_req(1'b0, 1'b1, 1'b0, 2'd1, 32'h0000_0400, 32'd0);
    sample();
    check("t5_idle_bus_req", bus_if.req, 32'd0);
    drive_cycle();
    serve(1'b0, 1'b0, 2'd1, 32'h0000_0400, 32'd0, 32'hCAFE_0001, "t5");

    // Reset during WAIT with data as owner.
    drive_cycle();
    set_req(1'b1, 1'b1, 1'b0, 2'd2, 32'h0000_0040, 32'd0);
    drive_cycle();
    bus_if.addr_ok = 1'b1;
    drive_cycle();
    bus_if.addr_ok = 1'b0;
    set_req(1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
    bus_if.data_ok = 1'b1;
    bus_if.rdata   = 32'd0;
    #1;
    check("t6_wait_fwd", data_if.data_ok, 32'd1);
    rst = 1'b0;
    #1;
    check("t6_rst_async_dok", {data_if.data_ok, inst_if.data_ok}, 32'd0);
    sample();
    check("t6_rst_bus_req", bus_if.req, 32'd0);
    drive_cycle();
    rst = 1'b1;
    sample();
    check("t6_post_dok", {data_if.data_ok, inst_if.data_ok}, 32'd0);
    $display("txn t6: reset during WAIT, transaction abandoned");
    drive_cycle();
    bus_if.data_ok = 1'b0;
    set_req(1'b0, 1'b1, 1'b0, 2'd2, 32'h0000_0500, 32'd0);
    sample();
    check("t6_idle_bus_req", bus_if.req, 32'd0);
    drive_cycle();
    serve(1'b0, 1'b0, 2'd2, 32'h0000_0500, 32'd0, 32'h7777_8888, "t6");

    drive_cycle();
    sample();
    check("sb_empty", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
